// File: rtl/ram_lsu_bridge_pkg.sv
// ram_lsu_bridge_pkg: size encodings, lane masks and bus widths shared by the data-RAM bridge.
package ram_lsu_bridge_pkg;
  localparam int BUS_W = 32;
  typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_X = 2'b11} size_e;
  typedef enum logic {S_IDLE, S_RMW} state_e;
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;
  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_W ? off == 2'b00 : size == SIZE_H ? !off[0] : size == SIZE_B;
  endfunction
endpackage

// File: rtl/ram_lane_align.sv
// ram_lane_align: byte-select generation, store lane replication and load lane extraction/extension.
module ram_lane_align
  import ram_lsu_bridge_pkg::*;
(
  input  logic [1:0]       size_i,
  input  logic [1:0]       off_i,
  input  logic             unsigned_i,
  input  logic [BUS_W-1:0] wdata_i,
  input  logic [BUS_W-1:0] rword_i,
  output logic             legal_o,
  output logic [3:0]       sel_o,
  output logic [BUS_W-1:0] wrep_o,
  output logic [BUS_W-1:0] rext_o
);
  logic [BUS_W-1:0] w_shift;
  // A legal half always has off_i[0] = 0, so one byte-granular shift serves both sizes.
  assign w_shift = rword_i >> {off_i, 3'b000};
  assign legal_o = size_legal(size_i, off_i);
  assign sel_o   = size_i == SIZE_W ? MASK_W : size_i == SIZE_H ? (off_i[1] ? MASK_H << 2 : MASK_H) : MASK_B << off_i;
  assign wrep_o  = size_i == SIZE_W ? wdata_i : size_i == SIZE_H ? {2{wdata_i[15:0]}} : {4{wdata_i[7:0]}};
  assign rext_o  = size_i == SIZE_W ? rword_i
                 : size_i == SIZE_H ? {{16{!unsigned_i & w_shift[15]}}, w_shift[15:0]}
                 : {{24{!unsigned_i & w_shift[7]}}, w_shift[7:0]};
endmodule

// File: rtl/ram_lsu_bridge.sv
// ram_lsu_bridge: turns core load/store requests into word-addressed RAM accesses,
// pacing partial stores around the RAM's two-cycle read-modify-write.
module ram_lsu_bridge
  import ram_lsu_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  output logic              ready_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic              ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic [3:0]        ram_sel_o,
  input  logic [DATA_W-1:0] ram_data_i
);
  state_e            r_state;
  logic              r_ack, r_err;
  logic [DATA_W-1:0] r_rdata;
  logic              w_acc, w_legal, w_drive, w_partial;
  logic [3:0]        w_sel;
  logic [DATA_W-1:0] w_wrep, w_rext;
  ram_lane_align u_align (
    .size_i    (size_i),
    .off_i     (addr_i[1:0]),
    .unsigned_i(unsigned_i),
    .wdata_i   (wdata_i),
    .rword_i   (ram_data_i),
    .legal_o   (w_legal),
    .sel_o     (w_sel),
    .wrep_o    (w_wrep),
    .rext_o    (w_rext)
  );
  assign ready_o   = r_state == S_IDLE;
  // Gating with rst keeps the RAM port quiet the instant reset is applied.
  assign w_acc     = req_i & ready_o & rst;
  assign w_drive   = w_acc & w_legal;
  assign w_partial = w_drive & we_i & (size_i != SIZE_W);
  assign ram_we_o   = w_drive & we_i;
  assign ram_addr_o = w_drive ? addr_i : '0;
  assign ram_sel_o  = w_drive ? w_sel : 4'b0000;
  assign ram_data_o = w_drive ? w_wrep : '0;
  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_partial ? S_RMW : S_IDLE;
      r_ack   <= (w_acc & !w_partial) | (r_state == S_RMW);
      r_err   <= w_acc & !w_legal;
      if (w_acc & (!w_legal | !we_i)) r_rdata <= w_legal ? w_rext : '0;
    end
  end
endmodule

// File: tb/tb_ram_lsu_bridge.sv
// tb_ram_lsu_bridge: directed and random requests against a byte-level reference memory,
// with a behavioural two-cycle RMW RAM attached to the bridge.
module tb_ram_lsu_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        ready, ack, err, ram_we;
  logic [31:0] rdata, ram_addr, ram_data, ram_rd;
  logic [3:0]  ram_sel;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd = 32'h0;
  logic [7:0]  ref_mem [0:255];

  ram_lsu_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req), .ready_o(ready), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .size_i(size), .unsigned_i(uns), .ack_o(ack), .err_o(err),
    .rdata_o(rdata), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_data_o(ram_data),
    .ram_sel_o(ram_sel), .ram_data_i(ram_rd)
  );

  always #5 clk = ~clk;

  // RAM: full-word writes land at once; partial writes capture the old word, merge one cycle later.
  logic [31:0] mem [0:16383];
  logic        p_v;
  logic [13:0] p_a;
  logic [3:0]  p_s;
  logic [31:0] p_d, p_old;
  assign ram_rd = mem[ram_addr[15:2]];
  always @(posedge clk) begin
    p_v <= 1'b0;
    if (p_v) mem[p_a] <= (p_old & ~{{8{p_s[3]}}, {8{p_s[2]}}, {8{p_s[1]}}, {8{p_s[0]}}})
                       | (p_d & {{8{p_s[3]}}, {8{p_s[2]}}, {8{p_s[1]}}, {8{p_s[0]}}});
    if (ram_we) begin
      if (ram_sel == 4'hF) mem[ram_addr[15:2]] <= ram_data;
      else begin
        p_v   <= 1'b1;
        p_a   <= ram_addr[15:2];
        p_s   <= ram_sel;
        p_d   <= ram_data;
        p_old <= mem[ram_addr[15:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic legal(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd2 ? a[1:0] == 2'b00 : sz == 2'd1 ? a[0] == 1'b0 : sz == 2'd0;
  endfunction

  function automatic logic [3:0] exp_sel(input logic [1:0] sz, input logic [31:0] a);
    int n = nbytes(sz);
    return 4'(((1 << n) - 1) << a[1:0]);
  endfunction

  function automatic logic [31:0] exp_rep(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] v = 32'h0;
    int n = nbytes(sz);
    for (int k = 0; k < 4; k++) v[8*k +: 8] = wd[8*(k % n) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v = 32'h0;
    int n = nbytes(sz);
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[8'(a + 32'(k))];
    if (!u && n < 4 && v[8*n-1]) for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int k = 0; k < nbytes(sz); k++) ref_mem[8'(a + 32'(k))] = wd[8*k +: 8];
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz, input logic u);
    req = 1'b1; we = w; addr = a; wdata = wd; size = sz; uns = u;
  endtask

  // Called 1-2 time units after a rising edge; returns 2 units after the ack edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz, input logic u);
    logic        lg = legal(sz, a);
    logic [31:0] ld = 32'h0;
    if (!w && lg) ld = ref_load(a, sz, u);
    drive(w, a, wd, sz, u);
    #1;
    chk("acc_ready", 32'(ready), 32'h1);
    chk("acc_ram_we", 32'(ram_we), 32'(w & lg));
    chk("acc_ram_sel", 32'(ram_sel), lg ? 32'(exp_sel(sz, a)) : 32'h0);
    chk("acc_ram_addr", ram_addr, lg ? a : 32'h0);
    if (w && lg) begin
      chk("acc_ram_data", ram_data, exp_rep(sz, wd));
      ref_store(a, sz, wd);
    end
    @(posedge clk); #1;
    req = 1'b0;
    #1;
    if (w && lg && sz != 2'd2) begin
      chk("rmw_ready", 32'(ready), 32'h0);
      chk("rmw_ram_we", 32'(ram_we), 32'h0);
      chk("rmw_ram_sel", 32'(ram_sel), 32'h0);
      chk("rmw_ack", 32'(ack), 32'h0);
      @(posedge clk); #2;
    end
    if (!lg) exp_rd = 32'h0;
    else if (!w) exp_rd = ld;
    chk("ack", 32'(ack), 32'h1);
    chk("err", 32'(err), 32'(!lg));
    chk("rdata", rdata, exp_rd);
    chk("we_pulse", 32'(ram_we), 32'h0);
  endtask

  initial begin
    logic [31:0] ld;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'd0; uns = 1'b0;
    #2;
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 17; i++) xfer(1'b1, 32'h100 + 32'(4*i), $urandom, 2'd2, 1'b0);
    xfer(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
    xfer(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    chk("lw_deadbeef", rdata, 32'hDEADBEEF);
    xfer(1'b1, 32'h100, 32'h11223344, 2'd2, 1'b0);
    xfer(1'b1, 32'h102, 32'h0000005A, 2'd0, 1'b0);
    xfer(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    chk("lw_merged", rdata, 32'h115A3344);
    xfer(1'b1, 32'h104, 32'h80FF7F01, 2'd2, 1'b0);
    xfer(1'b0, 32'h107, 32'h0, 2'd0, 1'b0);
    chk("lb_neg", rdata, 32'hFFFFFF80);
    xfer(1'b0, 32'h107, 32'h0, 2'd0, 1'b1);
    chk("lbu", rdata, 32'h00000080);
    xfer(1'b0, 32'h104, 32'h0, 2'd1, 1'b0);
    chk("lh_pos", rdata, 32'h00007F01);
    xfer(1'b0, 32'h106, 32'h0, 2'd1, 1'b1);
    chk("lhu", rdata, 32'h000080FF);
    xfer(1'b0, 32'h102, 32'h0, 2'd2, 1'b0);
    xfer(1'b1, 32'h101, 32'h1234, 2'd1, 1'b0);
    xfer(1'b0, 32'h100, 32'h0, 2'd3, 1'b0);
    xfer(1'b1, 32'h108, 32'hCAFE, 2'd3, 1'b0);
    // Four back-to-back loads, then a byte store whose follow-up load is held through RMW.
    xfer(1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
    xfer(1'b0, 32'h104, 32'h0, 2'd1, 1'b0);
    xfer(1'b0, 32'h107, 32'h0, 2'd0, 1'b1);
    xfer(1'b0, 32'h10A, 32'h0, 2'd1, 1'b0);
    drive(1'b1, 32'h109, 32'h000000A5, 2'd0, 1'b0);
    #1;
    chk("hb_ram_we", 32'(ram_we), 32'h1);
    chk("hb_ram_sel", 32'(ram_sel), 32'h2);
    chk("hb_ram_data", ram_data, 32'hA5A5A5A5);
    ref_store(32'h109, 2'd0, 32'hA5);
    ld = ref_load(32'h108, 2'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 32'h108, 32'h0, 2'd2, 1'b0);
    #1;
    chk("hold_ready", 32'(ready), 32'h0);
    chk("hold_ram_addr", ram_addr, 32'h0);
    chk("hold_ack", 32'(ack), 32'h0);
    @(posedge clk); #1;
    chk("hold_st_ack", 32'(ack), 32'h1);
    chk("hold_accept", 32'(ready), 32'h1);
    chk("hold_ram_addr2", ram_addr, 32'h108);
    chk("hold_ram_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    chk("hold_ld_ack", 32'(ack), 32'h1);
    chk("hold_ld_data", rdata, ld);
    exp_rd = ld;
    #1;
    for (int i = 0; i < 80; i++)
      xfer(1'($urandom), 32'h100 + ($urandom % 64), $urandom, 2'($urandom), 1'($urandom));
    // Reset applied in the RMW cycle abandons the ack; the RAM still finishes its merge.
    drive(1'b1, 32'h10C, 32'h0000BEEF, 2'd1, 1'b0);
    ref_store(32'h10C, 2'd1, 32'hBEEF);
    @(posedge clk); #1;
    req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rr_ready", 32'(ready), 32'h1);
    chk("rr_ack", 32'(ack), 32'h0);
    chk("rr_err", 32'(err), 32'h0);
    chk("rr_rdata", rdata, 32'h0);
    chk("rr_ram_we", 32'(ram_we), 32'h0);
    chk("rr_ram_sel", 32'(ram_sel), 32'h0);
    chk("rr_ram_addr", ram_addr, 32'h0);
    @(posedge clk); #1;
    chk("rr_ack_after", 32'(ack), 32'h0);
    rst = 1'b1;
    exp_rd = 32'h0;
    #1;
    xfer(1'b0, 32'h10C, 32'h0, 2'd2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
